// File: rtl/reg35_arbiter.sv
// reg35_arbiter: round-robin arbiter feeding a single WIDTH-bit register stage.
// One grant per cycle; the captured word is offered downstream with valid/ready.
// Optional grant counter enabled by defining REG35_ARB_STATS_EN.
//
//   state | meaning
//   ------+---------------------------------------------
//   EMPTY | stage holds no word, out_valid=0
//   FULL  | stage holds a word, out_valid=1
module reg35_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 35,
    parameter int CNTW  = 16,
    localparam int SRCW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SRCW-1:0]       out_src,
    input  logic                  out_ready,
    output logic                  busy
`ifdef REG35_ARB_STATS_EN
    ,
    output logic [CNTW-1:0]       grant_count
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SRCW-1:0]    src_q, src_d;
    logic [SRCW-1:0]    rr_ptr_q, rr_ptr_d;

    logic               can_load;
    logic               gnt_found;
    logic [SRCW-1:0]    gnt_idx;
    logic [WIDTH-1:0]   gnt_word;
    int                 srch_idx;

    // Round-robin search starting just after the last granted requester, plus next-state.
    always_comb begin
        can_load  = (state_q == EMPTY) || out_ready;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_word  = '0;
        srch_idx  = 0;
        req_ready = '0;
        if (can_load) begin
            for (int k = 1; k <= NREQ; k++) begin
                srch_idx = (int'(rr_ptr_q) + k) % NREQ;
                if (!gnt_found && req_valid[srch_idx]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = SRCW'(srch_idx);
                    gnt_word  = req_data[srch_idx*WIDTH +: WIDTH];
                end
            end
        end
        if (gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end

        state_d  = state_q;
        data_d   = data_q;
        src_d    = src_q;
        rr_ptr_d = rr_ptr_q;
        if (gnt_found) begin
            state_d  = FULL;
            data_d   = gnt_word;
            src_d    = gnt_idx;
            rr_ptr_d = gnt_idx;
        end else if (state_q == FULL && out_ready) begin
            // Drain with nothing to reload: keep last data/src, just go empty.
            state_d = EMPTY;
        end
    end

    // Stage FSM and held word; reset points rr_ptr at NREQ-1 so requester 0 wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= EMPTY;
            data_q   <= '0;
            src_q    <= '0;
            rr_ptr_q <= SRCW'(NREQ - 1);
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            src_q    <= src_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;
    assign busy      = (state_q == FULL) && !out_ready;

`ifdef REG35_ARB_STATS_EN
    logic [CNTW-1:0] grant_cnt_q;

    // Saturating count of accepted words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt_q <= '0;
        end else if (gnt_found && (grant_cnt_q != {CNTW{1'b1}})) begin
            grant_cnt_q <= grant_cnt_q + 1'b1;
        end
    end

    assign grant_count = grant_cnt_q;
`endif

endmodule

// File: tb/tb_reg35_arbiter.sv
// Testbench for reg35_arbiter: table-driven vectors plus directed corner sequences.
module tb_reg35_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 35;
    localparam int CNTW  = 16;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [1:0]            out_src;
    logic                  out_ready = 1'b0;
    logic                  busy;
`ifdef REG35_ARB_STATS_EN
    logic [CNTW-1:0]       grant_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    reg35_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .busy       (busy)
`ifdef REG35_ARB_STATS_EN
        ,
        .grant_count(grant_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rv;
        logic       ordy;
        logic [3:0] rdy;
        logic       bsy;
        logic       vld;
        logic [1:0] src;
    } vec_t;

    vec_t vec [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] word_of(input int i);
        logic [WIDTH-1:0] w;
        w = 35'h5_A5A0_0000 + WIDTH'(i * 17 + 3);
        return w;
    endfunction

    task automatic set_word(input int i, input logic [WIDTH-1:0] w);
        req_data[i*WIDTH +: WIDTH] = w;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset the DUT and leave time just after a rising edge.
    task automatic do_reset();
        req_valid = '0;
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        vec[0]  = '{4'b0001, 1'b1, 4'b0001, 1'b0, 1'b1, 2'd0};
        vec[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b0, 1'b1, 2'd1};
        vec[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b0, 1'b1, 2'd2};
        vec[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b0, 1'b1, 2'd3};
        vec[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 1'b1, 2'd0};
        vec[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b0, 1'b1, 2'd1};
        vec[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1};
        vec[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1};
        vec[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd1};
        vec[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd1};
        vec[10] = '{4'b1001, 1'b1, 4'b1000, 1'b0, 1'b1, 2'd3};
        vec[11] = '{4'b1001, 1'b1, 4'b0001, 1'b0, 1'b1, 2'd0};
        vec[12] = '{4'b1001, 1'b1, 4'b1000, 1'b0, 1'b1, 2'd3};
        vec[13] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd3};
        vec[14] = '{4'b0100, 1'b1, 4'b0100, 1'b0, 1'b1, 2'd2};
        vec[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2};
        vec[16] = '{4'b0011, 1'b1, 4'b0001, 1'b0, 1'b1, 2'd0};

        // Reset state
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data",  64'(out_data),  64'd0);
        chk("rst_src",   64'(out_src),   64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        tick();
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Table-driven sequence
        for (int i = 0; i < NREQ; i++) set_word(i, word_of(i));
        for (int v = 0; v < 17; v++) begin
            req_valid = vec[v].rv;
            out_ready = vec[v].ordy;
            #1;
            chk($sformatf("v%0d_req_ready", v), 64'(req_ready), 64'(vec[v].rdy));
            chk($sformatf("v%0d_busy", v),      64'(busy),      64'(vec[v].bsy));
            tick();
            chk($sformatf("v%0d_out_valid", v), 64'(out_valid), 64'(vec[v].vld));
            chk($sformatf("v%0d_out_src", v),   64'(out_src),   64'(vec[v].src));
            chk($sformatf("v%0d_out_data", v),  64'(out_data),  64'(word_of(int'(vec[v].src))));
        end

        // Single request with all-ones word
        do_reset();
        set_word(0, 35'h7_FFFF_FFFF);
        req_valid = 4'b0001;
        out_ready = 1'b1;
        #1;
        chk("single_req_ready", 64'(req_ready), 64'b0001);
        tick();
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_data",  64'(out_data),  64'h7_FFFF_FFFF);
        chk("single_src",   64'(out_src),   64'd0);

        // Backpressure: hold 1_2345_6789 for 5 stalled cycles
        do_reset();
        set_word(0, 35'h1_2345_6789);
        req_valid = 4'b0001;
        out_ready = 1'b1;
        tick();
        req_valid = 4'b1111;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp%0d_req_ready", c), 64'(req_ready), 64'd0);
            chk($sformatf("bp%0d_busy", c),      64'(busy),      64'd1);
            tick();
            chk($sformatf("bp%0d_data", c),      64'(out_data),  64'h1_2345_6789);
            chk($sformatf("bp%0d_valid", c),     64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_req_ready", 64'(req_ready), 64'b0010);
        tick();
        chk("bp_release_src", 64'(out_src), 64'd1);

        // Drain plus load without a bubble, then drain to empty
        set_word(2, 35'h0_0000_00AA);
        req_valid = 4'b0100;
        out_ready = 1'b1;
        #1;
        chk("dl_req_ready", 64'(req_ready), 64'b0100);
        tick();
        chk("dl_valid", 64'(out_valid), 64'd1);
        chk("dl_data",  64'(out_data),  64'h0_0000_00AA);
        chk("dl_src",   64'(out_src),   64'd2);
        req_valid = 4'b0000;
        tick();
        chk("dl_empty_valid", 64'(out_valid), 64'd0);
        chk("dl_empty_src",   64'(out_src),   64'd2);

        // Reset asserted between edges while stalled
        req_valid = 4'b0001;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("ms_busy_before", 64'(busy), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ms_valid_async", 64'(out_valid), 64'd0);
        chk("ms_data_async",  64'(out_data),  64'd0);
        @(negedge clk);
        reset = 1'b1;
        req_valid = 4'b1010;
        out_ready = 1'b1;
        #1;
        chk("ms_first_req_ready", 64'(req_ready), 64'b0010);
        tick();
        chk("ms_first_src", 64'(out_src), 64'd1);

`ifdef REG35_ARB_STATS_EN
        do_reset();
        chk("stat_rst", 64'(grant_count), 64'd0);
        req_valid = 4'b0001;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        req_valid = 4'b0000;
        tick();
        chk("stat_ten", 64'(grant_count), 64'd10);
        @(negedge clk);
        force dut.grant_cnt_q = 16'hFFFE;
        #1;
        release dut.grant_cnt_q;
        req_valid = 4'b0001;
        for (int c = 0; c < 3; c++) tick();
        req_valid = 4'b0000;
        tick();
        chk("stat_sat", 64'(grant_count), 64'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
